// File: rtl/prv_trap_ctrl.sv
// prv_trap_ctrl: machine-mode trap/return sequencer driving CSR update strobes and the fetch redirect.
// Define VECTORED_INT_EN to dispatch interrupts to mtvec base + 4*cause when mtvec[1:0]==2'b01.
module prv_trap_ctrl #(
    parameter int XLEN = 32,
    parameter logic [1:0] MPP_M = 2'b11
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [15:0]     exc_vec,
    input  logic [XLEN-1:0] exc_epc,
    input  logic [XLEN-1:0] exc_badaddr,
    input  logic            soft_int,
    input  logic            timer_int,
    input  logic            ext_int,
    input  logic            mret,
    input  logic            pipe_clear,
    output logic            flush_req,
    output logic            insert_pc,
    output logic [XLEN-1:0] priv_pc,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic [XLEN-1:0] mie,
    input  logic [XLEN-1:0] mip,
    input  logic [XLEN-1:0] mcause,
    input  logic [XLEN-1:0] mstatus,
    output logic            mip_rup,
    output logic            mcause_rup,
    output logic            mepc_rup,
    output logic            mbadaddr_rup,
    output logic            mstatus_rup,
    output logic [XLEN-1:0] mip_next,
    output logic [XLEN-1:0] mcause_next,
    output logic [XLEN-1:0] mepc_next,
    output logic [XLEN-1:0] mbadaddr_next,
    output logic [XLEN-1:0] mstatus_next
);
    localparam logic [XLEN-1:0] INT_MASK = XLEN'(12'h888);
    typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;
    state_t state, state_d;
    logic cap_int, cap_ret, exc_any, int_take, go, bad_code, unused_ok;
    logic [3:0] cap_cause, exc_code, int_code;
    logic [XLEN-1:0] cap_epc, cap_bad, mip_val, irq, base, trap_pc, trap_status, ret_status;
    assign unused_ok = ^{mcause, mtvec[1:0]};
    always_comb begin
        mip_val = mip;
        mip_val[3] = soft_int;
        mip_val[7] = timer_int;
        mip_val[11] = ext_int;
        irq = mip & mie & INT_MASK;
        int_take = mstatus[3] & |irq;
        int_code = irq[11] ? 4'd11 : irq[3] ? 4'd3 : 4'd7;
        exc_any = |(exc_vec & 16'h08ff);
        // later assignments win, so this runs lowest to highest priority
        exc_code = 4'd0;
        if (exc_vec[7]) exc_code = 4'd7;
        if (exc_vec[5]) exc_code = 4'd5;
        if (exc_vec[6]) exc_code = 4'd6;
        if (exc_vec[4]) exc_code = 4'd4;
        if (exc_vec[11]) exc_code = 4'd11;
        if (exc_vec[2]) exc_code = 4'd2;
        if (exc_vec[0]) exc_code = 4'd0;
        if (exc_vec[1]) exc_code = 4'd1;
        if (exc_vec[3]) exc_code = 4'd3;
        state_d = state == IDLE ? ((exc_any | int_take | mret) ? DRAIN : IDLE) :
                  state == DRAIN ? (pipe_clear ? COMMIT : DRAIN) :
                  state == COMMIT ? REDIRECT : IDLE;
        go = state == DRAIN && pipe_clear;
        bad_code = !cap_int && !cap_ret && cap_cause < 4'd8 && cap_cause != 4'd2 && cap_cause != 4'd3;
        trap_status = mstatus;
        trap_status[7] = mstatus[3];
        trap_status[3] = 1'b0;
        trap_status[12:11] = MPP_M;
        ret_status = mstatus;
        ret_status[3] = mstatus[7];
        ret_status[7] = 1'b1;
        base = {mtvec[XLEN-1:2], 2'b00};
    end
`ifdef VECTORED_INT_EN
    assign trap_pc = cap_int && mtvec[1:0] == 2'b01 ? base + (XLEN'(cap_cause) << 2) : base;
`else
    assign trap_pc = base;
`endif
    assign flush_req = state != IDLE;
    assign insert_pc = state == REDIRECT;
    // mepc is read live here so a return sees any write made during COMMIT
    assign priv_pc = state != REDIRECT ? '0 : cap_ret ? mepc : trap_pc;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cap_int <= 1'b0;
            cap_ret <= 1'b0;
            cap_cause <= '0;
            cap_epc <= '0;
            cap_bad <= '0;
            mip_rup <= 1'b0;
            mcause_rup <= 1'b0;
            mepc_rup <= 1'b0;
            mbadaddr_rup <= 1'b0;
            mstatus_rup <= 1'b0;
            mip_next <= '0;
            mcause_next <= '0;
            mepc_next <= '0;
            mbadaddr_next <= '0;
            mstatus_next <= '0;
        end else begin
            state <= state_d;
            mip_next <= mip_val;
            mip_rup <= mip_val != mip;
            if (state == IDLE) begin
                cap_int <= !exc_any && int_take;
                cap_ret <= !exc_any && !int_take;
                cap_cause <= exc_any ? exc_code : int_code;
                cap_epc <= exc_epc;
                cap_bad <= exc_badaddr;
            end
            mcause_rup <= go && !cap_ret;
            mepc_rup <= go && !cap_ret;
            mbadaddr_rup <= go && bad_code;
            mstatus_rup <= go;
            if (go && !cap_ret) begin
                mcause_next <= {cap_int, {(XLEN-5){1'b0}}, cap_cause};
                mepc_next <= cap_epc;
            end
            if (go && bad_code) mbadaddr_next <= cap_bad;
            if (go) mstatus_next <= cap_ret ? ret_status : trap_status;
        end
    end
endmodule

// File: tb/tb_prv_trap_ctrl.sv
// tb_prv_trap_ctrl: scoreboard bench for prv_trap_ctrl with a spec-level trap model and an emulated CSR file.
module tb_prv_trap_ctrl;
    logic CLK = 1'b0, RST = 1'b1;
    logic [15:0] exc_vec;
    logic [31:0] exc_epc, exc_badaddr, mtvec, mepc, mie, mip, mcause, mstatus;
    logic soft_int, timer_int, ext_int, mret, pipe_clear;
    logic flush_req, insert_pc, mip_rup, mcause_rup, mepc_rup, mbadaddr_rup, mstatus_rup;
    logic [31:0] priv_pc, mip_next, mcause_next, mepc_next, mbadaddr_next, mstatus_next;

    prv_trap_ctrl dut (
        .CLK(CLK), .RST(RST), .exc_vec(exc_vec), .exc_epc(exc_epc), .exc_badaddr(exc_badaddr),
        .soft_int(soft_int), .timer_int(timer_int), .ext_int(ext_int), .mret(mret),
        .pipe_clear(pipe_clear), .flush_req(flush_req), .insert_pc(insert_pc), .priv_pc(priv_pc),
        .mtvec(mtvec), .mepc(mepc), .mie(mie), .mip(mip), .mcause(mcause), .mstatus(mstatus),
        .mip_rup(mip_rup), .mcause_rup(mcause_rup), .mepc_rup(mepc_rup),
        .mbadaddr_rup(mbadaddr_rup), .mstatus_rup(mstatus_rup), .mip_next(mip_next),
        .mcause_next(mcause_next), .mepc_next(mepc_next), .mbadaddr_next(mbadaddr_next),
        .mstatus_next(mstatus_next)
    );

    always #5 CLK = ~CLK;

    localparam int EPRI[9] = '{3, 1, 0, 2, 11, 4, 6, 5, 7};
    localparam int IPRI[3] = '{11, 3, 7};

    typedef struct {int cyc; logic [3:0] rup; logic [31:0] cause, epc, bad, status;} commit_t;
    typedef struct {int cyc; logic [31:0] pc;} redir_t;
    commit_t cq[$];
    redir_t rq[$];
    commit_t ce;
    redir_t re;
    int tests = 0, fails = 0, cyc = 0;
    logic exp_flush = 1'b0;
    logic [31:0] emip = 0;
    logic emrup = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mip_after();
        logic [31:0] m;
        m = mip;
        m[3] = soft_int;
        m[7] = timer_int;
        m[11] = ext_int;
        return m;
    endfunction

    // Which event the controller should take, straight from the priority rules
    function automatic void predict(input logic [15:0] ev, input logic mr, output bit has,
                                    output bit isint, output bit isret, output logic [3:0] code);
        has = 1; isint = 0; isret = 0; code = 0;
        for (int i = 0; i < 9; i++) if (ev[EPRI[i]]) begin code = 4'(EPRI[i]); return; end
        if (mstatus[3])
            for (int i = 0; i < 3; i++)
                if (mip[IPRI[i]] && mie[IPRI[i]]) begin isint = 1; code = 4'(IPRI[i]); return; end
        if (mr) begin isret = 1; return; end
        has = 0;
    endfunction

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        emip <= RST ? 32'h0 : mip_after();
        emrup <= RST ? 1'b0 : (mip_after() != mip);
    end

    always @(negedge CLK) begin
        chk("flush_req", 32'(flush_req), 32'(exp_flush));
        chk("mip_next", mip_next, RST ? 32'h0 : emip);
        chk("mip_rup", 32'(mip_rup), RST ? 32'h0 : 32'(emrup));
        if (mcause_rup | mepc_rup | mstatus_rup | mbadaddr_rup) begin
            if (cq.size() == 0) chk("commit_unexpected", 32'({mcause_rup, mepc_rup, mbadaddr_rup, mstatus_rup}), 32'h0);
            else begin
                ce = cq.pop_front();
                chk("commit_cycle", cyc, ce.cyc);
                chk("rup_mask", 32'({mcause_rup, mepc_rup, mbadaddr_rup, mstatus_rup}), 32'(ce.rup));
                if (ce.rup[3]) chk("mcause_next", mcause_next, ce.cause);
                if (ce.rup[2]) chk("mepc_next", mepc_next, ce.epc);
                if (ce.rup[1]) chk("mbadaddr_next", mbadaddr_next, ce.bad);
                chk("mstatus_next", mstatus_next, ce.status);
            end
        end
        if (insert_pc) begin
            if (rq.size() == 0) chk("redirect_unexpected", 32'(insert_pc), 32'h0);
            else begin
                re = rq.pop_front();
                chk("redirect_cycle", cyc, re.cyc);
                chk("priv_pc", priv_pc, re.pc);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // ln = {ext, timer, soft}; d = cycles pipe_clear stays low in DRAIN
    task automatic run(input logic [15:0] ev, input logic [2:0] ln, input logic mr, input logic [31:0] epc,
                       input logic [31:0] bad, input logic [31:0] tv, input logic [31:0] ie, input int d);
        bit has, isint, isret, badv;
        logic [3:0] code;
        logic [31:0] st, pc;
        int n;
        {ext_int, timer_int, soft_int} = ln;
        exc_vec = 0; mret = 0; mie = 0; mtvec = tv;
        tick();
        tick();
        mip = mip_after();
        mie = ie; exc_vec = ev; mret = mr; exc_epc = epc; exc_badaddr = bad;
        predict(ev, mr, has, isint, isret, code);
        if (!has) begin
            tick();
            exc_vec = 0; mret = 0; mie = 0;
            return;
        end
        n = cyc;
        st = mstatus;
        if (isret) begin
            st[3] = mstatus[7];
            st[7] = 1'b1;
            pc = mepc;
        end else begin
            st[7] = mstatus[3];
            st[3] = 1'b0;
            st[12:11] = 2'b11;
            pc = tv & ~32'h3;
`ifdef VECTORED_INT_EN
            if (isint && tv[1:0] == 2'b01) pc = pc + 32'(code) * 4;
`endif
        end
        badv = !isint && !isret && (code inside {0, 1, 4, 5, 6, 7});
        cq.push_back('{n + 2 + d, isret ? 4'b0001 : {2'b11, badv, 1'b1},
                       {isint, 27'b0, code}, epc, bad, st});
        rq.push_back('{n + 3 + d, pc});
        tick();
        exp_flush = 1;
        for (int i = 0; i < d; i++) begin
            pipe_clear = 0; exc_vec = 16'($urandom); mret = 1'($urandom);
            tick();
        end
        pipe_clear = 1; exc_vec = 16'($urandom); mret = 1'($urandom);
        tick();
        pipe_clear = 1'($urandom);
        tick();
        mstatus = st;
        if (!isret) begin mepc = epc; mcause = {isint, 27'b0, code}; end
        mie = 0; exc_vec = 0; mret = 0;
        tick();
        exp_flush = 0;
    endtask

    initial begin
        exc_vec = 0; exc_epc = 0; exc_badaddr = 0; mtvec = 0; mepc = 0; mie = 0; mip = 0;
        mcause = 0; mstatus = 0; soft_int = 0; timer_int = 0; ext_int = 0; mret = 0; pipe_clear = 1;
        @(negedge CLK);
        chk("reset_flags", 32'({mip_rup, mcause_rup, mepc_rup, mbadaddr_rup, mstatus_rup, insert_pc, flush_req}), 32'h0);
        chk("reset_priv_pc", priv_pc, 32'h0);
        chk("reset_nexts", mcause_next | mepc_next | mbadaddr_next | mstatus_next | mip_next, 32'h0);
        tick();
        RST = 0;
        tick();
        mstatus = 32'h8;
        run(16'h0004, 3'b000, 0, 32'h100, 32'h0, 32'h200, 32'h0, 0);
        mstatus = 32'h8;
        run(16'h0020, 3'b010, 1, 32'h300, 32'hDEAD0000, 32'h200, 32'h80, 1);
        run(16'h0000, 3'b010, 0, 32'h304, 32'h0, 32'h200, 32'h80, 0);
        mstatus = 32'h8;
        run(16'h0000, 3'b010, 0, 32'h500, 32'h0, 32'h201, 32'h80, 0);
        mstatus = 32'h80; mepc = 32'h400;
        run(16'h0000, 3'b000, 1, 32'h0, 32'h0, 32'h200, 32'h0, 0);
        run(16'h0800, 3'b000, 0, 32'h600, 32'h0, 32'h200, 32'h0, 5);
        exc_vec = 16'h0004; exc_epc = 32'h700;
        tick();
        exp_flush = 1; exc_vec = 0; pipe_clear = 0;
        tick();
        tick();
        RST = 1;
        exp_flush = 0;
        cq.delete();
        rq.delete();
        tick();
        RST = 0;
        repeat (3) tick();
        pipe_clear = 1;
        for (int t = 0; t < 150; t++) begin
            logic [15:0] ev;
            ev = ($urandom % 3 == 0) ? 16'h0 : ($urandom % 2) ? 16'(1 << $urandom_range(0, 15)) : 16'($urandom);
            if ($urandom % 2) mstatus = $urandom;
            if ($urandom % 4 == 0) mepc = $urandom;
            mip = $urandom & ~32'h888;
            run(ev, 3'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 3));
        end
        repeat (3) tick();
        chk("commit_queue_drained", 32'(cq.size()), 32'h0);
        chk("redirect_queue_drained", 32'(rq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
